// File: rtl/ram64_block_mover_if.sv
// Handshake and RAM-port bundle for ram64_block_mover.
// slave = mover side, master = controller side, mem = the RAM instance.
interface ram64_block_mover_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              start;
  logic              fill;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] pattern;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  start, fill, src, dst, len, pattern, mem_out,
    output busy, done, mem_address, mem_in, mem_load
  );

  modport master (
    output start, fill, src, dst, len, pattern,
    input  busy, done
  );

  modport mem (
    input  mem_address, mem_in, mem_load,
    output mem_out
  );
endinterface

// File: rtl/ram64_block_mover.sv
// Block copy / fill engine and sole master of one 64x16 RAM while busy.
// state   | meaning
// S_IDLE  | waiting for start; RAM port quiet
// S_READ  | copy only: present src_ptr, capture RAM word into buffer
// S_WRITE | write buffer (copy) or pattern (fill) at dst_ptr
// S_DONE  | one-cycle done pulse
module ram64_block_mover #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ram64_block_mover_if.slave   bus_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [ADDR_W:0]     count_q,   count_d;
  logic [DATA_W-1:0]   buf_q,     buf_d;
  logic                fill_q,    fill_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic [ADDR_W:0]     len_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
    end
  end

  // Lengths above a full RAM clamp to one pass over every address.
  assign len_sat = (bus_if.len > MAX_LEN) ? MAX_LEN : bus_if.len;

  always_comb begin
    state_d            = state_q;
    src_ptr_d          = src_ptr_q;
    dst_ptr_d          = dst_ptr_q;
    count_d            = count_q;
    buf_d              = buf_q;
    fill_d             = fill_q;
    pattern_d          = pattern_q;
    bus_if.busy        = 1'b0;
    bus_if.done        = 1'b0;
    bus_if.mem_address = '0;
    bus_if.mem_in      = '0;
    bus_if.mem_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          src_ptr_d = bus_if.src;
          dst_ptr_d = bus_if.dst;
          count_d   = len_sat;
          fill_d    = bus_if.fill;
          pattern_d = bus_if.pattern;
          if (len_sat == '0)
            state_d = S_DONE;
          else if (bus_if.fill)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end

      S_READ: begin
        bus_if.busy        = 1'b1;
        bus_if.mem_address = src_ptr_q;
        buf_d              = bus_if.mem_out;
        state_d            = S_WRITE;
      end

      S_WRITE: begin
        bus_if.busy        = 1'b1;
        bus_if.mem_address = dst_ptr_q;
        bus_if.mem_load    = 1'b1;
        bus_if.mem_in      = fill_q ? pattern_q : buf_q;
        // Pointers wrap naturally at the address width.
        src_ptr_d          = src_ptr_q + PTR_ONE;
        dst_ptr_d          = dst_ptr_q + PTR_ONE;
        count_d            = count_q - CNT_ONE;
        if (count_q == CNT_ONE)
          state_d = S_DONE;
        else if (fill_q)
          state_d = S_WRITE;
        else
          state_d = S_READ;
      end

      S_DONE: begin
        bus_if.done = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram64_block_mover.sv
// Directed bench for ram64_block_mover against a behavioural 64x16 RAM.
module tb_ram64_block_mover;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [15:0] ram [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [15:0] pre_data;

  ram64_block_mover_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  ram64_block_mover #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_out = ram[bus.mem_address];

  always @(posedge clk) begin
    if (pre_we)
      ram[pre_addr] <= pre_data;
    else if (bus.mem_load)
      ram[bus.mem_address] <= bus.mem_in;
  end

  task automatic poke(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic preload_mult3();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 6'(i);
      pre_data = 16'(i * 3);
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one start pulse and watches the operation until done (bounded).
  task automatic run_op(input logic f, input logic [5:0] s, input logic [5:0] d,
                        input logic [6:0] l, input logic [15:0] p,
                        output int busy_n, output int load_n, output int done_at,
                        output logic done_again);
    @(negedge clk);
    bus.fill    = f;
    bus.src     = s;
    bus.dst     = d;
    bus.len     = l;
    bus.pattern = p;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    busy_n     = 0;
    load_n     = 0;
    done_at    = -1;
    done_again = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.mem_load) load_n++;
      if (bus.done) begin
        done_at = n;
        break;
      end
      if (bus.busy) busy_n++;
      @(negedge clk);
    end
    if (done_at >= 0) begin
      @(negedge clk);
      done_again = bus.done | bus.busy;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    bus.start = 1'b0; bus.fill = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len   = '0;   bus.pattern = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.mem_load} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl busy/done/load=%b expected 000", {bus.busy, bus.done, bus.mem_load});
    end
    checks++;
    if (bus.mem_address !== 6'd0 || bus.mem_in !== 16'd0) begin
      failures++;
      $display("FAIL reset_bus addr=%0d in=%h expected 0/0000", bus.mem_address, bus.mem_in);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy();
    int b, ld, dn;
    logic again;
    preload_mult3();
    run_op(1'b0, 6'd4, 6'd40, 7'd5, 16'h0, b, ld, dn, again);
    checks++;
    if (dn !== 10) begin
      failures++;
      $display("FAIL copy_done_at got=%0d expected 10", dn);
    end
    checks++;
    if (b !== 10 || ld !== 5) begin
      failures++;
      $display("FAIL copy_busy_loads busy=%0d loads=%0d expected 10/5", b, ld);
    end
    checks++;
    if (again !== 1'b0) begin
      failures++;
      $display("FAIL copy_done_once got=%b expected 0", again);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ram[6'(40 + k)] !== 16'((4 + k) * 3)) begin
        failures++;
        $display("FAIL copy_dst[%0d] got=%0d expected %0d", 40 + k, ram[6'(40 + k)], (4 + k) * 3);
      end
      checks++;
      if (ram[6'(4 + k)] !== 16'((4 + k) * 3)) begin
        failures++;
        $display("FAIL copy_src[%0d] got=%0d expected %0d", 4 + k, ram[6'(4 + k)], (4 + k) * 3);
      end
    end
    checks++;
    if (ram[45] !== 16'd135) begin
      failures++;
      $display("FAIL copy_past_end got=%0d expected 135", ram[45]);
    end
  endtask

  task automatic test_fill_wrap();
    int b, ld, dn;
    logic again;
    logic [5:0] a;
    run_op(1'b1, 6'd0, 6'd60, 7'd6, 16'hBEEF, b, ld, dn, again);
    checks++;
    if (dn !== 6 || b !== 6 || ld !== 6) begin
      failures++;
      $display("FAIL fill_timing done_at=%0d busy=%0d loads=%0d expected 6/6/6", dn, b, ld);
    end
    for (int k = 0; k < 6; k++) begin
      a = 6'(60 + k);
      checks++;
      if (ram[a] !== 16'hBEEF) begin
        failures++;
        $display("FAIL fill_word[%0d] got=%h expected beef", a, ram[a]);
      end
    end
    checks++;
    if (ram[2] !== 16'd6 || ram[59] !== 16'd177) begin
      failures++;
      $display("FAIL fill_neighbours ram2=%0d ram59=%0d expected 6/177", ram[2], ram[59]);
    end
  endtask

  task automatic test_len0();
    int b, ld, dn;
    logic again;
    run_op(1'b0, 6'd4, 6'd30, 7'd0, 16'h0, b, ld, dn, again);
    checks++;
    if (dn !== 0 || b !== 0) begin
      failures++;
      $display("FAIL len0_done_at done_at=%0d busy=%0d expected 0/0", dn, b);
    end
    checks++;
    if (ld !== 0 || again !== 1'b0) begin
      failures++;
      $display("FAIL len0_quiet loads=%0d after=%b expected 0/0", ld, again);
    end
    checks++;
    if (ram[30] !== 16'd90) begin
      failures++;
      $display("FAIL len0_ram got=%0d expected 90", ram[30]);
    end
  endtask

  task automatic test_overlap();
    int b, ld, dn;
    logic again;
    for (int k = 0; k < 5; k++) poke(6'(10 + k), 16'(10 + k));
    run_op(1'b0, 6'd10, 6'd11, 7'd4, 16'h0, b, ld, dn, again);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram[6'(11 + k)] !== 16'hA) begin
        failures++;
        $display("FAIL overlap_fwd[%0d] got=%h expected a", 11 + k, ram[6'(11 + k)]);
      end
    end
    for (int k = 0; k < 5; k++) poke(6'(10 + k), 16'(10 + k));
    run_op(1'b0, 6'd11, 6'd10, 7'd4, 16'h0, b, ld, dn, again);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ram[6'(10 + k)] !== 16'(k == 4 ? 14 : 11 + k)) begin
        failures++;
        $display("FAIL overlap_rev[%0d] got=%h expected %h", 10 + k, ram[6'(10 + k)], (k == 4 ? 14 : 11 + k));
      end
    end
  endtask

  task automatic test_ignore_start();
    int b, dn;
    preload_mult3();
    @(negedge clk);
    bus.fill = 1'b0; bus.src = 6'd20; bus.dst = 6'd50; bus.len = 7'd3; bus.pattern = 16'h0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.fill = 1'b1; bus.src = 6'd0; bus.dst = 6'd0; bus.len = 7'd10; bus.pattern = 16'hFFFF;
    b  = 0;
    dn = -1;
    for (int n = 0; n < 50; n++) begin
      if (n == 4) bus.start = 1'b0;
      if (bus.done) begin
        dn = n;
        break;
      end
      if (bus.busy) b++;
      @(negedge clk);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_in_done busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    checks++;
    if (dn !== 6 || b !== 6) begin
      failures++;
      $display("FAIL ignore_timing done_at=%0d busy=%0d expected 6/6", dn, b);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ram[6'(50 + k)] !== 16'((20 + k) * 3)) begin
        failures++;
        $display("FAIL ignore_dst[%0d] got=%0d expected %0d", 50 + k, ram[6'(50 + k)], (20 + k) * 3);
      end
    end
    checks++;
    if (ram[0] !== 16'd0 || ram[53] !== 16'd159) begin
      failures++;
      $display("FAIL ignore_untouched ram0=%0d ram53=%0d expected 0/159", ram[0], ram[53]);
    end
  endtask

  task automatic test_len_saturate();
    int b, ld, dn;
    logic again;
    int idx [6] = '{0, 5, 31, 32, 33, 63};
    preload_mult3();
    run_op(1'b0, 6'd0, 6'd32, 7'd100, 16'h0, b, ld, dn, again);
    checks++;
    if (dn !== 128 || b !== 128 || ld !== 64) begin
      failures++;
      $display("FAIL sat_timing done_at=%0d busy=%0d loads=%0d expected 128/128/64", dn, b, ld);
    end
    foreach (idx[j]) begin
      checks++;
      if (ram[6'(idx[j])] !== 16'((idx[j] % 32) * 3)) begin
        failures++;
        $display("FAIL sat_word[%0d] got=%0d expected %0d", idx[j], ram[6'(idx[j])], (idx[j] % 32) * 3);
      end
    end
  endtask

  task automatic test_reset_abort();
    int b, ld, dn;
    logic again;
    logic seen_done;
    preload_mult3();
    @(negedge clk);
    bus.fill = 1'b1; bus.dst = 6'd20; bus.src = 6'd0; bus.len = 7'd10; bus.pattern = 16'h1234;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen_done = bus.done;
    repeat (3) begin
      @(negedge clk);
      seen_done |= bus.done;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_load !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_async load=%b busy=%b expected 0/0", bus.mem_load, bus.busy);
    end
    @(negedge clk);
    seen_done |= bus.done;
    reset = 1'b0;
    @(negedge clk);
    seen_done |= bus.done;
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got=%b expected 0", seen_done);
    end
    checks++;
    if (ram[20] !== 16'h1234 || ram[22] !== 16'h1234 || ram[23] !== 16'd69) begin
      failures++;
      $display("FAIL abort_words ram20=%h ram22=%h ram23=%h expected 1234/1234/0045", ram[20], ram[22], ram[23]);
    end
    run_op(1'b1, 6'd0, 6'd23, 7'd2, 16'h0055, b, ld, dn, again);
    checks++;
    if (dn !== 2 || ram[23] !== 16'h0055 || ram[24] !== 16'h0055 || ram[25] !== 16'd75) begin
      failures++;
      $display("FAIL abort_restart done_at=%0d ram23=%h ram24=%h ram25=%0d expected 2/0055/0055/75",
               dn, ram[23], ram[24], ram[25]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len0();
    test_overlap();
    test_ignore_start();
    test_len_saturate();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram64_block_mover.md
Name: ram64_block_mover

Overview:
- Memory-side initiator that drives the write/read port of a 64-word x 16-bit RAM: `in`, `address`, `load` out; `out` back in.
- Performs block copy (src -> dst) or block fill (constant pattern -> dst) of up to 64 words, under a start/busy/done handshake.
- Sits between a controller (CPU-side or test sequencer) and one ram64 instance; it is the RAM's sole master while busy.

Parameters:
- ADDR_W, 6, RAM address width; all pointer arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, RAM word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- fill  input  1  operation select, latched at start: 0 = copy, 1 = fill.
- src  input  ADDR_W  copy source base address, latched at start.
- dst  input  ADDR_W  destination base address, latched at start.
- len  input  ADDR_W+1  word count 0..64, latched at start; values >64 saturate to 64.
- pattern  input  DATA_W  fill value, latched at start.
- busy  output  1  high while in READ or WRITE.
- done  output  1  one-cycle completion pulse.
- mem_address  output  ADDR_W  drives RAM `address`.
- mem_in  output  DATA_W  drives RAM `in`.
- mem_load  output  1  drives RAM `load`; RAM writes on the clk edge while high.
- mem_out  input  DATA_W  RAM `out`; combinational read of mem_address.

Behaviour:
- Reset:
  - State goes to IDLE immediately, without waiting for clk.
  - busy=0, done=0, mem_load=0, mem_address=0, mem_in=0; internal pointers, count and buffer cleared.
  - Reset mid-transfer aborts it: words already written stay written, no done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs: mem_load=0, mem_address=0, mem_in=0.
  - On an edge with start=1, latch src, dst, saturated len, fill and pattern.
  - len=0 -> DONE. fill=1 -> WRITE. Otherwise -> READ.
- READ (copy only):
  - mem_address=src_ptr, mem_load=0.
  - At the edge: buf <= mem_out; go to WRITE.
- WRITE:
  - mem_address=dst_ptr, mem_load=1, mem_in = fill ? pattern : buf.
  - At the edge: dst_ptr+1, src_ptr+1 (both wrap 63->0), count-1.
  - If count was 1 -> DONE. Else fill ? WRITE : READ.
- DONE: done=1 and busy=0 for exactly one cycle, mem_load=0, then -> IDLE.
- Timing:
  - Copy of N words: busy for 2N cycles, then one done cycle.
  - Fill of N words: busy for N cycles, then one done cycle.
  - Start to first bus activity: 1 cycle (the state after the sampling edge).
- start while busy or in DONE: ignored. Latched operands are not disturbed by input changes after the start edge.
- Overlap: copy is strictly forward, word by word, read-then-write.
  - dst<=src: exact copy.
  - dst within (src, src+N): earlier written words are re-read, producing periodic replication. This is the defined behaviour, not an error.
- Wrap: a region crossing address 63 continues at 0. len=64 touches every address exactly once.
- mem_load is high only in WRITE; never two writes to one address within one operation unless len=64 wraps onto itself (impossible, so exactly once).

Test Plan:
- Reset, preload RAM[i]=i*3; copy src=4, dst=40, len=5 -> busy 10 cycles; RAM[40..44]=12,15,18,21,24; done pulses once; RAM[4..8] unchanged.
- Fill dst=60, len=6, pattern=16'hBEEF -> busy 6 cycles; RAM[60..63] and RAM[0..1]=BEEF; RAM[2]=6 unchanged.
- start with len=0 -> no mem_load ever high; done high exactly 1 cycle after the start edge; RAM unchanged.
- Overlapping copy src=10, dst=11, len=4 with RAM[10..14]=A,B,C,D,E -> RAM[11..14]=A,A,A,A; reverse case src=11, dst=10 -> RAM[10..13]=B,C,D,E.
- Second start pulse and changed src/dst/len during busy -> ignored; result matches the first request; len=100 behaves as 64 (128 busy cycles in copy).
- Assert reset asynchronously after 3 words of a 10-word fill -> mem_load drops before the next edge; only 3 words written; no done; a new start afterwards completes normally.
